// File: rtl/ambiente_pkg.sv
// rtl/ambiente_pkg.sv - shared cell codes, headings, states and neighbour helper for the grid world
package ambiente_pkg;

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] WALL   = 2'b01;
    localparam logic [1:0] DEBRIS = 2'b10;
    localparam logic [1:0] MARK   = 2'b11;

    typedef enum logic [1:0] {
        N = 2'd0,
        E = 2'd1,
        S = 2'd2,
        W = 2'd3
    } heading_t;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        TURN_R,
        TURN_L,
        REMOVE,
        SENSE
    } state_t;

    // Neighbour coordinates; off is set when the step would leave the grid
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        off;
    } cell_t;

    function automatic cell_t next_cell(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] d,
                                        input logic [15:0] w, input logic [15:0] h);
        cell_t c;
        c.x   = x;
        c.y   = y;
        c.off = 1'b0;
        case (d)
            N: if (y == 16'd0)         c.off = 1'b1; else c.y = y - 16'd1;
            E: if (x == w - 16'd1)     c.off = 1'b1; else c.x = x + 16'd1;
            S: if (y == h - 16'd1)     c.off = 1'b1; else c.y = y + 16'd1;
            default: if (x == 16'd0)   c.off = 1'b1; else c.x = x - 16'd1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ambiente_mapa.sv
// rtl/ambiente_mapa.sv - maze map storage with one write port and front/left/current read ports
module ambiente_mapa
    import ambiente_pkg::*;
#(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8,
    parameter int XW     = $clog2(GRID_W),
    parameter int YW     = $clog2(GRID_H),
    parameter int AW     = XW + YW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [1:0]    wdata,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    dir,
    output logic [1:0]    front_code,
    output logic [1:0]    left_code,
    output logic [1:0]    cur_code,
    output logic [XW-1:0] front_x,
    output logic [YW-1:0] front_y,
    output logic [AW-1:0] front_addr
);

    logic [1:0]    cells [GRID_W*GRID_H];
    cell_t         fc;
    cell_t         lc;
    logic [AW-1:0] left_addr;
    logic          unused_hi;

    // Map contents survive reset so a maze loaded once stays put across runs
    always_ff @(posedge clk) begin
        if (we) begin
            cells[waddr] <= wdata;
        end
    end

    // Neighbour lookup; off-grid cells look like walls to the robot
    always_comb begin
        fc         = next_cell(16'(x), 16'(y), dir, 16'(GRID_W), 16'(GRID_H));
        lc         = next_cell(16'(x), 16'(y), dir - 2'd1, 16'(GRID_W), 16'(GRID_H));
        front_x    = fc.x[XW-1:0];
        front_y    = fc.y[YW-1:0];
        front_addr = {front_y, front_x};
        left_addr  = {lc.y[YW-1:0], lc.x[XW-1:0]};
        front_code = fc.off ? WALL : cells[front_addr];
        left_code  = lc.off ? WALL : cells[left_addr];
        cur_code   = cells[{y, x}];
    end

    assign unused_hi = ^{fc.x[15:XW], fc.y[15:YW], lc.x[15:XW], lc.y[15:YW]};

endmodule

// File: rtl/ambiente_robo.sv
// rtl/ambiente_robo.sv - grid-world responder executing robot motion commands and regenerating sensors
module ambiente_robo
    import ambiente_pkg::*;
#(
    parameter int GRID_W        = 8,
    parameter int GRID_H        = 8,
    parameter int MOVE_CYCLES   = 4,
    parameter int TURN_CYCLES   = 2,
    parameter int REMOVE_CYCLES = 6,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int AW = $clog2(GRID_W*GRID_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          map_we,
    input  logic [AW-1:0] map_addr,
    input  logic [1:0]    map_data,
    input  logic          load_pose,
    input  logic [XW-1:0] start_x,
    input  logic [YW-1:0] start_y,
    input  logic [1:0]    start_dir,
    input  logic          avancar,
    input  logic          girar,
    input  logic          remover,
    output logic          head,
    output logic          left,
    output logic          under,
    output logic          barreira,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [1:0]    dir,
    output logic          busy,
    output logic          step_done,
    output logic          collision
);

    state_t        state;
    logic [7:0]    cnt;
    logic          arc;
    logic          blocked;
    logic [1:0]    front_code;
    logic [1:0]    left_code;
    logic [1:0]    cur_code;
    logic [XW-1:0] front_x;
    logic [YW-1:0] front_y;
    logic [AW-1:0] front_addr;
    logic          front_blocked;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_data;

    ambiente_mapa #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW),
        .AW     (AW)
    ) u_mapa (
        .clk        (clk),
        .we         (wr_en),
        .waddr      (wr_addr),
        .wdata      (wr_data),
        .x          (pos_x),
        .y          (pos_y),
        .dir        (dir),
        .front_code (front_code),
        .left_code  (left_code),
        .cur_code   (cur_code),
        .front_x    (front_x),
        .front_y    (front_y),
        .front_addr (front_addr)
    );

    assign front_blocked = (front_code == WALL) || (front_code == DEBRIS);
    assign busy          = (state != IDLE);

    // Single map write port shared by the host loader (idle only) and debris clearing
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = map_addr;
        wr_data = map_data;
        if (!reset) begin
            if (state == IDLE && map_we) begin
                wr_en = 1'b1;
            end else if (state == REMOVE && cnt == 8'd0) begin
                wr_en   = 1'b1;
                wr_addr = front_addr;
                wr_data = FREE;
            end
        end
    end

    // Action sequencer: sample commands in IDLE, count out the action, commit pose, refresh sensors
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            arc       <= 1'b0;
            blocked   <= 1'b0;
            pos_x     <= '0;
            pos_y     <= '0;
            dir       <= N;
            head      <= 1'b0;
            left      <= 1'b0;
            under     <= 1'b0;
            barreira  <= 1'b0;
            step_done <= 1'b0;
            collision <= 1'b0;
        end else begin
            step_done <= 1'b0;
            collision <= 1'b0;
            case (state)
                IDLE: begin
                    if (map_we || load_pose) begin
                        if (load_pose) begin
                            pos_x <= start_x;
                            pos_y <= start_y;
                            dir   <= start_dir;
                        end
                        state <= SENSE;
                    end else if (remover && barreira) begin
                        state <= REMOVE;
                        cnt   <= 8'(REMOVE_CYCLES - 1);
                    end else if (avancar) begin
                        state     <= MOVE;
                        cnt       <= 8'(MOVE_CYCLES - 1);
                        arc       <= girar;
                        blocked   <= front_blocked;
                        collision <= front_blocked;
                    end else if (girar) begin
                        state <= TURN_R;
                        cnt   <= 8'(TURN_CYCLES - 1);
                    end
                end
                MOVE: begin
                    if (cnt == 8'd0) begin
                        if (!blocked) begin
                            pos_x <= front_x;
                            pos_y <= front_y;
                        end
                        if (arc) begin
                            state <= TURN_L;
                            cnt   <= 8'(TURN_CYCLES - 1);
                        end else begin
                            step_done <= 1'b1;
                            state     <= SENSE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                TURN_R: begin
                    if (cnt == 8'd0) begin
                        dir       <= dir + 2'd1;
                        step_done <= 1'b1;
                        state     <= SENSE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                TURN_L: begin
                    if (cnt == 8'd0) begin
                        dir       <= dir - 2'd1;
                        step_done <= 1'b1;
                        state     <= SENSE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                REMOVE: begin
                    if (cnt == 8'd0) begin
                        step_done <= 1'b1;
                        state     <= SENSE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SENSE: begin
                    head     <= (front_code == WALL);
                    left     <= (left_code == WALL);
                    under    <= (cur_code == MARK);
                    barreira <= (front_code == DEBRIS);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ambiente_robo.sv
// tb/tb_ambiente_robo.sv - self-checking bench for ambiente_robo against a grid-world reference model
module tb_ambiente_robo;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int MC = 4;
    localparam int TC = 2;
    localparam int RC = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       map_we;
    logic [5:0] map_addr;
    logic [1:0] map_data;
    logic       load_pose;
    logic [2:0] start_x;
    logic [2:0] start_y;
    logic [1:0] start_dir;
    logic       avancar;
    logic       girar;
    logic       remover;
    logic       head;
    logic       left;
    logic       under;
    logic       barreira;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [1:0] dir;
    logic       busy;
    logic       step_done;
    logic       collision;

    int checks = 0;
    int errors = 0;

    int mm [64];
    int px;
    int py;
    int pd;
    int dx [4] = '{0, 1, 0, -1};
    int dy [4] = '{-1, 0, 1, 0};

    ambiente_robo #(
        .GRID_W        (GW),
        .GRID_H        (GH),
        .MOVE_CYCLES   (MC),
        .TURN_CYCLES   (TC),
        .REMOVE_CYCLES (RC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .map_we    (map_we),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .load_pose (load_pose),
        .start_x   (start_x),
        .start_y   (start_y),
        .start_dir (start_dir),
        .avancar   (avancar),
        .girar     (girar),
        .remover   (remover),
        .head      (head),
        .left      (left),
        .under     (under),
        .barreira  (barreira),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .dir       (dir),
        .busy      (busy),
        .step_done (step_done),
        .collision (collision)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Cell code seen one step from the model pose in heading d; outside the grid is wall
    function automatic int code_at(input int d);
        int fx;
        int fy;
        fx = px + dx[d];
        fy = py + dy[d];
        if (fx < 0 || fx >= GW || fy < 0 || fy >= GH) return 1;
        return mm[fy*GW + fx];
    endfunction

    task automatic check_sensors(input string tag);
        check({tag, "/head"},     head,     (code_at(pd) == 1));
        check({tag, "/left"},     left,     (code_at((pd + 3) % 4) == 1));
        check({tag, "/under"},    under,    (mm[py*GW + px] == 3));
        check({tag, "/barreira"}, barreira, (code_at(pd) == 2));
        check({tag, "/pos_x"},    pos_x,    px);
        check({tag, "/pos_y"},    pos_y,    py);
        check({tag, "/dir"},      dir,      pd);
        check({tag, "/busy"},     busy,     0);
    endtask

    task automatic write_cell(input int x, input int y, input int c, input string tag);
        map_addr = 6'(y*GW + x);
        map_data = 2'(c);
        map_we   = 1'b1;
        tick();
        map_we   = 1'b0;
        mm[y*GW + x] = c;
        tick();
        check_sensors(tag);
    endtask

    task automatic load(input int x, input int y, input int d, input string tag);
        start_x   = 3'(x);
        start_y   = 3'(y);
        start_dir = 2'(d);
        load_pose = 1'b1;
        tick();
        load_pose = 1'b0;
        px = x;
        py = y;
        pd = d;
        tick();
        check_sensors(tag);
    endtask

    task automatic clear_inputs();
        avancar = 1'b0;
        girar   = 1'b0;
        remover = 1'b0;
        map_we  = 1'b0;
    endtask

    // Issue one command for one cycle, then follow it to completion against the model
    task automatic run_cmd(input logic av, input logic gi, input logic rm, input bit noise, input string tag);
        bit do_rm;
        bit do_mv;
        bit do_tr;
        bit blk;
        int lat;
        int n;
        int c;
        do_rm = rm && (code_at(pd) == 2);
        do_mv = !do_rm && av;
        do_tr = !do_rm && !av && gi;
        c     = code_at(pd);
        blk   = do_mv && (c == 1 || c == 2);
        avancar = av;
        girar   = gi;
        remover = rm;
        tick();
        clear_inputs();
        if (!(do_rm || do_mv || do_tr)) begin
            check({tag, "/idle_busy"}, busy, 0);
            check({tag, "/idle_step"}, step_done, 0);
            return;
        end
        check({tag, "/collision"}, collision, blk);
        check({tag, "/busy"}, busy, 1);
        lat = do_rm ? RC : (do_mv ? (MC + (gi ? TC : 0)) : TC);
        n = 0;
        while (!step_done && n < 40) begin
            if (noise) begin
                avancar  = 1'($urandom_range(1));
                girar    = 1'($urandom_range(1));
                remover  = 1'($urandom_range(1));
                map_we   = 1'($urandom_range(1));
                map_addr = 6'($urandom_range(63));
                map_data = 2'($urandom_range(3));
            end
            tick();
            n++;
        end
        clear_inputs();
        check({tag, "/latency"}, n, lat);
        if (do_rm) begin
            mm[(py + dy[pd])*GW + (px + dx[pd])] = 0;
        end
        if (do_mv) begin
            if (!blk) begin
                px = px + dx[pd];
                py = py + dy[pd];
            end
            if (gi) pd = (pd + 3) % 4;
        end
        if (do_tr) pd = (pd + 1) % 4;
        check({tag, "/pos_x_done"}, pos_x, px);
        check({tag, "/pos_y_done"}, pos_y, py);
        check({tag, "/dir_done"},   dir,   pd);
        tick();
        check({tag, "/step_once"}, step_done, 0);
        check_sensors(tag);
    endtask

    initial begin
        int r;
        bit seen;
        reset     = 1'b1;
        map_we    = 1'b0;
        map_addr  = '0;
        map_data  = '0;
        load_pose = 1'b0;
        start_x   = '0;
        start_y   = '0;
        start_dir = '0;
        avancar   = 1'b0;
        girar     = 1'b0;
        remover   = 1'b0;
        px = 0;
        py = 0;
        pd = 0;
        tick();
        tick();
        reset = 1'b0;

        check("rst/pos_x", pos_x, 0);
        check("rst/pos_y", pos_y, 0);
        check("rst/dir", dir, 0);
        check("rst/busy", busy, 0);
        check("rst/sensors", {head, left, under, barreira}, 0);
        check("rst/pulses", {step_done, collision}, 0);

        for (int i = 0; i < 64; i++) write_cell(i % GW, i / GW, 0, "clear");

        load(3, 3, 1, "load33E");
        check("load33E/all_clear", {head, left, under, barreira}, 0);

        write_cell(4, 3, 1, "wall43");
        check("wall43/head", head, 1);
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, "blocked");
        check("blocked/head_after", head, 1);

        write_cell(4, 3, 0, "free43");
        run_cmd(1'b1, 1'b0, 1'b0, 1'b1, "fwd");
        check("fwd/pos_x", pos_x, 4);

        load(0, 0, 0, "load00N");
        run_cmd(1'b0, 1'b1, 1'b0, 1'b0, "turn_r");
        check("turn_r/dir", dir, 1);
        run_cmd(1'b1, 1'b1, 1'b0, 1'b0, "arc");
        check("arc/pos", {pos_x, pos_y, dir}, {3'd1, 3'd0, 2'd0});
        check("arc/edge_head", head, 1);

        write_cell(2, 0, 2, "debris20");
        load(1, 0, 1, "load10E");
        check("debris/barreira", barreira, 1);
        check("debris/head_excl", head, 0);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0, "remove");
        check("remove/barreira", barreira, 0);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0, "remove_ign");

        load(2, 2, 1, "load22E");
        avancar = 1'b1;
        tick();
        avancar = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("midrst/pos", {pos_x, pos_y, dir}, 0);
        check("midrst/busy", busy, 0);
        check("midrst/step", step_done, 0);
        reset = 1'b0;
        px = 0;
        py = 0;
        pd = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | step_done | busy;
        end
        check("midrst/quiet", seen, 0);
        map_addr = 6'd0;
        map_data = 2'd3;
        map_we   = 1'b1;
        tick();
        map_we   = 1'b0;
        mm[0]    = 3;
        tick();
        load(0, 0, 0, "mark00");
        check("mark00/under", under, 1);

        for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(9));
            write_cell(i % GW, i / GW, (r < 2) ? 1 : (r == 2) ? 2 : (r == 3) ? 3 : 0, "rmap");
        end
        load(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(3)), "rpose");
        for (int k = 0; k < 60; k++) begin
            if (k % 15 == 14)
                load(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(3)), "rreload");
            run_cmd(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
